// File: rtl/mp_add_stream_pkg.sv
// Shared widths, FSM state type and result-word layout for the multi-precision add stream.
package mp_add_stream_pkg;

    localparam int WORD_W = 16;
    localparam int IDX_W  = 8;

    typedef enum logic {
        FIRST = 1'b0,
        MID   = 1'b1
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] sum;
        logic              last;
        logic              carry;
        logic              ovf;
        logic [IDX_W-1:0]  idx;
    } res_t;

endpackage

// File: rtl/mp_add_stream_prefix_adder.sv
// 16-bit Kogge-Stone adder with carry-in; purely combinational.
module prefix_adder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    logic [15:0] gen;
    logic [15:0] prop;
    logic [15:0] gk;
    logic [15:0] pk;
    logic [15:0] gn;
    logic [15:0] pn;
    logic [16:0] c;

    always_comb begin
        gen  = a & b;
        prop = a ^ b;
        gk   = gen;
        pk   = prop;
        gn   = gen;
        pn   = prop;
        // Four doubling levels give group generate/propagate over bits [i:0].
        for (int l = 0; l < 4; l++) begin
            gn = gk;
            pn = pk;
            for (int i = 0; i < 16; i++) begin
                if (i >= (1 << l)) begin
                    gn[i] = gk[i] | (pk[i] & gk[4'(i - (1 << l))]);
                    pn[i] = pk[i] & pk[4'(i - (1 << l))];
                end
            end
            gk = gn;
            pk = pn;
        end
        c[0] = c_in;
        for (int i = 0; i < 16; i++) begin
            c[i+1] = gk[i] | (pk[i] & c_in);
        end
        sum   = prop ^ c[15:0];
        c_out = c[16];
    end

endmodule

// File: rtl/mp_add_stream.sv
// Streams multi-word add/subtract, LSW first, carry chained through a register.
// Latency 1 cycle; single output register, in_ready = !out_valid | out_ready.
import mp_add_stream_pkg::*;

module mp_add_stream (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic              in_last,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_carry,
    output logic              out_ovf,
    output logic [IDX_W-1:0]  out_idx
);

    state_e            state;
    logic              mode;
    logic              carry_q;
    logic [IDX_W-1:0]  idx_q;
    res_t              res_q;

    logic              xfer;
    logic              first;
    logic              mode_cur;
    logic [WORD_W-1:0] b_eff;
    logic              c_in;
    logic [WORD_W-1:0] sum;
    logic              c_out;
    logic [IDX_W-1:0]  idx_cur;
    res_t              res_d;

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;
    assign first    = (state == FIRST);

    // The first word's in_sub takes effect immediately, before mode is latched.
    assign mode_cur = first ? in_sub : mode;
    assign b_eff    = mode_cur ? ~in_b : in_b;
    assign c_in     = first ? mode_cur : carry_q;
    assign idx_cur  = first ? '0 : idx_q;

    prefix_adder_16 u_adder (
        .a     (in_a),
        .b     (b_eff),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out)
    );

    always_comb begin
        res_d       = '0;
        res_d.sum   = sum;
        res_d.last  = in_last;
        res_d.carry = in_last && c_out;
        res_d.ovf   = in_last && (in_a[WORD_W-1] == b_eff[WORD_W-1])
                              && (sum[WORD_W-1] != in_a[WORD_W-1]);
        res_d.idx   = idx_cur;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FIRST;
            mode      <= 1'b0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            res_q     <= '0;
        end else begin
            if (xfer) begin
                state     <= in_last ? FIRST : MID;
                if (first) begin
                    mode <= in_sub;
                end
                carry_q   <= c_out;
                idx_q     <= in_last ? '0 : idx_cur + IDX_W'(1);
                out_valid <= 1'b1;
                res_q     <= res_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_sum   = res_q.sum;
    assign out_last  = res_q.last;
    assign out_carry = res_q.carry;
    assign out_ovf   = res_q.ovf;
    assign out_idx   = res_q.idx;

endmodule
